integer_datapath: RTL and testbench

//  MIPS-style integer datapath of the multicycle CPU, driven by the MCU. Holds the
//  32x32 register file, RS/RT/ALU_Out/D_in pipeline registers, HI/LO, a 32-bit ALU
//  and the write-back (Y) mux. ALU_OUT feeds PC load and data-memory/IO address;
//  D_OUT is the store data; DY returns load data.

---
 rtl/integer_datapath_pkg.sv | 30 +++
 rtl/integer_datapath_regfile_32x32.sv | 38 +++
 rtl/integer_datapath.sv | 179 +++++++++++++++++
 tb/tb_integer_datapath.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/integer_datapath_pkg.sv
// Shared encodings for the integer datapath.
//   fs_e    : ALU function-select opcodes carried on FS
//   ysel_e  : write-back source select carried on Y_Sel
//   dasel_e : register-file write-address select carried on DA_sel
//   SP_INIT_DEFAULT : reset value of r29 ($sp)
package integer_datapath_pkg;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_03FC;
  localparam logic [4:0]  REG_RA = 5'd31;
  localparam logic [4:0]  REG_SP = 5'd29;

  typedef enum logic [4:0] {
    FS_PASS_S = 5'h00, FS_PASS_T = 5'h01, FS_ADD  = 5'h02, FS_ADDU = 5'h03,
    FS_SUB    = 5'h04, FS_SUBU   = 5'h05, FS_SLT  = 5'h06, FS_SLTU = 5'h07,
    FS_AND    = 5'h08, FS_OR     = 5'h09, FS_XOR  = 5'h0A, FS_NOR  = 5'h0B,
    FS_SRL    = 5'h0C, FS_SRA    = 5'h0D, FS_SLL  = 5'h0E, FS_ANDI = 5'h0F,
    FS_ORI    = 5'h10, FS_LUI    = 5'h11, FS_XORI = 5'h12, FS_INC1 = 5'h13,
    FS_INC4   = 5'h14, FS_DEC1   = 5'h15, FS_DEC4 = 5'h16, FS_ZERO = 5'h17,
    FS_ONES   = 5'h18, FS_MULT   = 5'h1E, FS_DIV  = 5'h1F
  } fs_e;

  typedef enum logic [2:0] {
    YS_ALU = 3'd0, YS_HI = 3'd1, YS_LO = 3'd2, YS_DIN = 3'd3, YS_PC = 3'd4
  } ysel_e;

  typedef enum logic [1:0] {
    DA_RD = 2'd0, DA_RT = 2'd1, DA_RA = 2'd2, DA_SP = 2'd3
  } dasel_e;

endpackage

// File: rtl/integer_datapath_regfile_32x32.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
//   clk, rst         : clock / async active-high reset
//   we_i, waddr_i, wdata_i : write port (writes to r0 are dropped)
//   raddr_s_i/rdata_s_o, raddr_t_i/rdata_t_o : read ports, r0 always reads 0
// On reset every register clears except r29, which loads SP_INIT.
module regfile_32x32
  import integer_datapath_pkg::*;
#(
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_s_i,
  input  logic [4:0]  raddr_t_i,
  output logic [31:0] rdata_s_o,
  output logic [31:0] rdata_t_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 32'(REG_SP)) ? SP_INIT : '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  assign rdata_s_o = (raddr_s_i == 5'd0) ? '0 : regs_q[raddr_s_i];
  assign rdata_t_o = (raddr_t_i == 5'd0) ? '0 : regs_q[raddr_t_i];

endmodule

// File: rtl/integer_datapath.sv
// MIPS-style multicycle integer datapath: register file, RS/RT/ALU_Out/D_in
// pipeline registers, HI/LO, 32-bit ALU with 64-bit mult/div result, and the
// write-back mux.
//   CLK/RESET     : clock, async active-high reset
//   FS, SHAMT, DT, T_Sel : ALU function, shift amount, immediate, T-operand select
//   HILO_ld       : capture ALU 64-bit result into HI/LO
//   D_En, D_Addr, S_Addr, T_Addr, DA_sel : register-file control and addresses
//   PC_in, DY, Y_Sel : write-back sources and select
//   C, V, N, Z    : combinational ALU flags
//   ALU_OUT       : ALU_Out register;  D_OUT : RT register (store data)
module integer_datapath
  import integer_datapath_pkg::*;
#(
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  FS,
  input  logic        HILO_ld,
  input  logic        D_En,
  input  logic [4:0]  D_Addr,
  input  logic [4:0]  S_Addr,
  input  logic [4:0]  T_Addr,
  input  logic [4:0]  SHAMT,
  input  logic [31:0] DT,
  input  logic        T_Sel,
  input  logic [31:0] PC_in,
  input  logic [1:0]  DA_sel,
  input  logic [31:0] DY,
  input  logic [2:0]  Y_Sel,
  output logic        C,
  output logic        V,
  output logic        N,
  output logic        Z,
  output logic [31:0] ALU_OUT,
  output logic [31:0] D_OUT
);

  logic [31:0] rs_q, rt_q, alu_out_q, din_q, hi_q, lo_q;
  logic [31:0] rf_s, rf_t;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;

  logic [31:0] t_op, arith_b, y_lo, y_hi;
  logic        arith_en, arith_sub, wide;
  logic [32:0] arith_r;
  logic [63:0] prod;
  logic [31:0] quot, rem;

  regfile_32x32 #(.SP_INIT(SP_INIT)) u_rf (
    .clk       (CLK),
    .rst       (RESET),
    .we_i      (D_En),
    .waddr_i   (waddr_d),
    .wdata_i   (wdata_d),
    .raddr_s_i (S_Addr),
    .raddr_t_i (T_Addr),
    .rdata_s_o (rf_s),
    .rdata_t_o (rf_t)
  );

  always_comb begin
    waddr_d = D_Addr;
    case (DA_sel)
      DA_RT:   waddr_d = T_Addr;
      DA_RA:   waddr_d = REG_RA;
      DA_SP:   waddr_d = REG_SP;
      default: waddr_d = D_Addr;
    endcase
  end

  always_comb begin
    wdata_d = alu_out_q;
    case (Y_Sel)
      YS_HI:   wdata_d = hi_q;
      YS_LO:   wdata_d = lo_q;
      YS_DIN:  wdata_d = din_q;
      YS_PC:   wdata_d = PC_in;
      default: wdata_d = alu_out_q;
    endcase
  end

  // Adds, subtracts and the inc/dec ops share one 33-bit adder so carry and
  // overflow are derived in a single place.
  always_comb begin
    t_op      = T_Sel ? DT : rt_q;
    arith_en  = 1'b1;
    arith_sub = 1'b0;
    arith_b   = t_op;
    case (FS)
      FS_ADD, FS_ADDU: ;
      FS_SUB, FS_SUBU: arith_sub = 1'b1;
      FS_INC1: arith_b = 32'd1;
      FS_INC4: arith_b = 32'd4;
      FS_DEC1: begin arith_b = 32'd1; arith_sub = 1'b1; end
      FS_DEC4: begin arith_b = 32'd4; arith_sub = 1'b1; end
      default: arith_en = 1'b0;
    endcase
    arith_r = arith_sub ? ({1'b0, rs_q} - {1'b0, arith_b})
                        : ({1'b0, rs_q} + {1'b0, arith_b});
  end

  always_comb begin
    prod = $signed({{32{rs_q[31]}}, rs_q}) * $signed({{32{t_op[31]}}, t_op});
    if (t_op == '0) begin
      quot = '1;
      rem  = rs_q;
    end else begin
      quot = $signed(rs_q) / $signed(t_op);
      rem  = $signed(rs_q) % $signed(t_op);
    end
  end

  always_comb begin
    y_lo = '0;
    y_hi = '0;
    wide = 1'b0;
    case (FS)
      FS_PASS_S: y_lo = rs_q;
      FS_PASS_T: y_lo = t_op;
      FS_ADD, FS_ADDU, FS_SUB, FS_SUBU,
      FS_INC1, FS_INC4, FS_DEC1, FS_DEC4: y_lo = arith_r[31:0];
      FS_SLT:  y_lo = {31'd0, $signed(rs_q) < $signed(t_op)};
      FS_SLTU: y_lo = {31'd0, rs_q < t_op};
      FS_AND:  y_lo = rs_q & t_op;
      FS_OR:   y_lo = rs_q | t_op;
      FS_XOR:  y_lo = rs_q ^ t_op;
      FS_NOR:  y_lo = ~(rs_q | t_op);
      FS_SRL:  y_lo = t_op >> SHAMT;
      FS_SRA:  y_lo = $signed(t_op) >>> SHAMT;
      FS_SLL:  y_lo = t_op << SHAMT;
      FS_ANDI: y_lo = rs_q & {16'h0, t_op[15:0]};
      FS_ORI:  y_lo = rs_q | {16'h0, t_op[15:0]};
      FS_LUI:  y_lo = {t_op[15:0], 16'h0};
      FS_XORI: y_lo = rs_q ^ {16'h0, t_op[15:0]};
      FS_ZERO: y_lo = '0;
      FS_ONES: y_lo = '1;
      FS_MULT: begin {y_hi, y_lo} = prod; wide = 1'b1; end
      FS_DIV:  begin y_lo = quot; y_hi = rem; wide = 1'b1; end
      default: y_lo = '0;
    endcase
  end

  always_comb begin
    C = 1'b0;
    V = 1'b0;
    if (arith_en) begin
      C = arith_r[32];
      V = arith_sub ? ((rs_q[31] != arith_b[31]) && (arith_r[31] != rs_q[31]))
                    : ((rs_q[31] == arith_b[31]) && (arith_r[31] != rs_q[31]));
    end
    N = wide ? y_hi[31] : y_lo[31];
    Z = wide ? ({y_hi, y_lo} == 64'd0) : (y_lo == 32'd0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rs_q      <= '0;
      rt_q      <= '0;
      alu_out_q <= '0;
      din_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      rs_q      <= rf_s;
      rt_q      <= rf_t;
      alu_out_q <= y_lo;
      din_q     <= DY;
      if (HILO_ld) begin
        hi_q <= y_hi;
        lo_q <= y_lo;
      end
    end
  end

  assign ALU_OUT = alu_out_q;
  assign D_OUT   = rt_q;

endmodule

// File: tb/tb_integer_datapath.sv
module tb_integer_datapath;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  FS, D_Addr, S_Addr, T_Addr, SHAMT;
  logic        HILO_ld, D_En, T_Sel;
  logic [31:0] DT, PC_in, DY;
  logic [1:0]  DA_sel;
  logic [2:0]  Y_Sel;
  logic        C, V, N, Z;
  logic [31:0] ALU_OUT, D_OUT;

  int checks = 0;
  int failures = 0;

  integer_datapath #(.SP_INIT(32'h0000_03FC)) dut (
    .CLK(CLK), .RESET(RESET), .FS(FS), .HILO_ld(HILO_ld), .D_En(D_En),
    .D_Addr(D_Addr), .S_Addr(S_Addr), .T_Addr(T_Addr), .SHAMT(SHAMT),
    .DT(DT), .T_Sel(T_Sel), .PC_in(PC_in), .DA_sel(DA_sel), .DY(DY),
    .Y_Sel(Y_Sel), .C(C), .V(V), .N(N), .Z(Z), .ALU_OUT(ALU_OUT), .D_OUT(D_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ALU passes T (immediate) into ALU_Out, then writes ALU_Out into r[addr].
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] val);
    FS = 5'h01; T_Sel = 1'b1; DT = val; Y_Sel = 3'd0;
    tick();
    D_En = 1'b1; DA_sel = 2'd1; T_Addr = addr;
    tick();
    D_En = 1'b0;
  endtask

  // Register contents appear on D_OUT one edge after T_Addr is set.
  task automatic read_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    T_Addr = addr;
    tick();
    check(tag, D_OUT, exp);
  endtask

  task automatic wb_hilo(input logic [2:0] ysel, input logic [4:0] addr);
    D_En = 1'b1; DA_sel = 2'd1; T_Addr = addr; Y_Sel = ysel;
    tick();
    D_En = 1'b0; Y_Sel = 3'd0;
  endtask

  initial begin
    RESET = 1'b1; FS = '0; HILO_ld = 1'b0; D_En = 1'b0; D_Addr = '0;
    S_Addr = '0; T_Addr = '0; SHAMT = '0; DT = '0; T_Sel = 1'b0;
    PC_in = '0; DA_sel = '0; DY = '0; Y_Sel = '0;
    tick(); tick();
    check("rst_alu_out", ALU_OUT, 32'h0);
    check("rst_d_out", D_OUT, 32'h0);
    RESET = 1'b0;

    // r29 reset value through passS
    S_Addr = 5'd29; FS = 5'h00;
    tick(); tick();
    check("sp_init", ALU_OUT, 32'h0000_03FC);

    // immediate written to r8
    write_reg(5'd8, 32'd5);
    read_reg("r8_write", 5'd8, 32'd5);

    // signed overflow on add
    write_reg(5'd9, 32'h7FFF_FFFF);
    S_Addr = 5'd9; tick();
    FS = 5'h02; T_Sel = 1'b1; DT = 32'd1; #1;
    check("add_flags_VNCZ", {28'd0, V, N, C, Z}, 32'b1100);
    tick();
    check("add_ovf_result", ALU_OUT, 32'h8000_0000);

    // mult -3 * 4
    write_reg(5'd10, 32'hFFFF_FFFD);
    S_Addr = 5'd10; tick();
    FS = 5'h1E; DT = 32'd4; T_Sel = 1'b1; HILO_ld = 1'b1; #1;
    check("mult_flags_VNCZ", {28'd0, V, N, C, Z}, 32'b0100);
    tick();
    HILO_ld = 1'b0;
    wb_hilo(3'd1, 5'd11);
    wb_hilo(3'd2, 5'd12);
    read_reg("mult_hi", 5'd11, 32'hFFFF_FFFF);
    read_reg("mult_lo", 5'd12, 32'hFFFF_FFF4);

    // r0 is hard-wired
    write_reg(5'd0, 32'h0000_DEAD);
    read_reg("r0_zero", 5'd0, 32'h0);

    // memory data write-back through D_in
    DY = 32'h0000_1234; tick();
    wb_hilo(3'd3, 5'd13);
    read_reg("din_wb", 5'd13, 32'h0000_1234);

    // divide by zero
    write_reg(5'd14, 32'd7);
    S_Addr = 5'd14; tick();
    FS = 5'h1F; DT = 32'd0; T_Sel = 1'b1; HILO_ld = 1'b1;
    tick();
    HILO_ld = 1'b0;
    check("div0_alu_out", ALU_OUT, 32'hFFFF_FFFF);
    wb_hilo(3'd1, 5'd15);
    wb_hilo(3'd2, 5'd16);
    read_reg("div0_hi", 5'd15, 32'h0000_0007);
    read_reg("div0_lo", 5'd16, 32'hFFFF_FFFF);

    // subtract with borrow, then equal operands (RS still holds r14 = 7)
    FS = 5'h04; DT = 32'd8; T_Sel = 1'b1; #1;
    check("sub_flags_VNCZ", {28'd0, V, N, C, Z}, 32'b0110);
    tick();
    check("sub_result", ALU_OUT, 32'hFFFF_FFFF);
    FS = 5'h05; DT = 32'd7; #1;
    check("subu_zero_VNCZ", {28'd0, V, N, C, Z}, 32'b0001);

    // signed vs unsigned compare: -3 against 4
    S_Addr = 5'd10; tick();
    FS = 5'h06; DT = 32'd4; tick();
    check("slt", ALU_OUT, 32'd1);
    FS = 5'h07; tick();
    check("sltu", ALU_OUT, 32'd0);

    // shifts
    FS = 5'h0E; SHAMT = 5'd4; DT = 32'd1; tick();
    check("sll", ALU_OUT, 32'h0000_0010);
    FS = 5'h0D; DT = 32'h8000_0000; tick();
    check("sra", ALU_OUT, 32'hF800_0000);
    FS = 5'h11; DT = 32'h0000_ABCD; tick();
    check("lui", ALU_OUT, 32'hABCD_0000);

    // link write to r31 while reading r31 in the same cycle
    PC_in = 32'h0000_0400; Y_Sel = 3'd4; DA_sel = 2'd2; D_En = 1'b1; T_Addr = 5'd31;
    tick();
    D_En = 1'b0; Y_Sel = 3'd0;
    check("same_cycle_old", D_OUT, 32'h0);
    tick();
    check("link_r31", D_OUT, 32'h0000_0400);

    // asynchronous reset mid-operation
    RESET = 1'b1; #1;
    check("midrst_alu_out", ALU_OUT, 32'h0);
    check("midrst_d_out", D_OUT, 32'h0);
    #2; RESET = 1'b0;
    read_reg("midrst_r8", 5'd8, 32'h0);
    read_reg("midrst_r29", 5'd29, 32'h0000_03FC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
